// File: rtl/alct_mux_phase_scan_pkg.sv
// rtl/alct_mux_phase_scan_pkg.sv - shared FSM encodings, constants and goodspots index helper
package alct_mux_phase_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_RECORD = 3'd4,
    ST_NEXT   = 3'd5,
    ST_PICK   = 3'd6,
    ST_DONE   = 3'd7
  } scan_state_e;

  localparam int CLR_CYCLES = 2;

  function automatic int unsigned gs_idx(input int unsigned p, input int unsigned d,
                                         input int unsigned nsteps);
    return p * nsteps + d;
  endfunction

endpackage

// File: rtl/alct_mux_window_find.sv
// rtl/alct_mux_window_find.sv - longest good run over both phases, one delay step per cycle
module alct_mux_window_find
  import alct_mux_phase_scan_pkg::*;
#(
  parameter int NSTEPS = 16,
  parameter int DLYW   = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [2*NSTEPS-1:0] goodspots,
  output logic                done,
  output logic                best_posneg,
  output logic [DLYW-1:0]     best_delay,
  output logic [DLYW:0]       best_len,
  output logic                nogood
);

  localparam int IW = $clog2(2 * NSTEPS);

  logic [2*NSTEPS-1:0] map_q, map_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                run_q, run_d, fin_q, fin_d;
  logic [DLYW:0]       cur_len_q, cur_len_d, bl_q, bl_d;
  logic [DLYW-1:0]     cur_start_q, cur_start_d, bs_q, bs_d;
  logic                bp_q, bp_d;
  logic [IW-1:0]       dstep;
  logic                pstep;
  logic [DLYW:0]       base_len, run_len;
  logic [DLYW-1:0]     run_start;

  always_comb begin
    map_d       = map_q;
    idx_d       = idx_q;
    run_d       = run_q;
    fin_d       = 1'b0;
    cur_len_d   = cur_len_q;
    cur_start_d = cur_start_q;
    bl_d        = bl_q;
    bs_d        = bs_q;
    bp_d        = bp_q;
    pstep       = (idx_q >= IW'(NSTEPS));
    dstep       = pstep ? idx_q - IW'(NSTEPS) : idx_q;
    // A run never continues across the phase boundary.
    base_len    = (dstep == '0) ? '0 : cur_len_q;
    run_len     = base_len + 1'b1;
    run_start   = (base_len == '0) ? DLYW'(dstep) : cur_start_q;
    if (start) begin
      map_d       = goodspots;
      idx_d       = '0;
      run_d       = 1'b1;
      cur_len_d   = '0;
      cur_start_d = '0;
      bl_d        = '0;
      bs_d        = '0;
      bp_d        = 1'b0;
    end else if (run_q) begin
      if (map_q[idx_q]) begin
        cur_len_d   = run_len;
        cur_start_d = run_start;
        // Strictly longer only: earlier runs and phase 0 keep ties.
        if (run_len > bl_q) begin
          bl_d = run_len;
          bs_d = run_start;
          bp_d = pstep;
        end
      end else begin
        cur_len_d = '0;
      end
      if (idx_q == IW'(2 * NSTEPS - 1)) begin
        run_d = 1'b0;
        fin_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      map_q       <= '0;
      idx_q       <= '0;
      run_q       <= 1'b0;
      fin_q       <= 1'b0;
      cur_len_q   <= '0;
      cur_start_q <= '0;
      bl_q        <= '0;
      bs_q        <= '0;
      bp_q        <= 1'b0;
    end else begin
      map_q       <= map_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      fin_q       <= fin_d;
      cur_len_q   <= cur_len_d;
      cur_start_q <= cur_start_d;
      bl_q        <= bl_d;
      bs_q        <= bs_d;
      bp_q        <= bp_d;
    end
  end

  assign done        = fin_q;
  assign nogood      = (bl_q == '0);
  assign best_len    = bl_q;
  assign best_posneg = bp_q;
  assign best_delay  = nogood ? '0 : bs_q + DLYW'((bl_q - 1'b1) >> 1);

endmodule

// File: rtl/alct_mux_phase_scan.sv
// rtl/alct_mux_phase_scan.sv - scans posneg x tx delay on the ALCT DDR mux and applies the best window
module alct_mux_phase_scan
  import alct_mux_phase_scan_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NSTEPS = 16,
  parameter int DLYW   = 4,
  parameter int SETTLE = 32,
  parameter int NCHECK = 256
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    rx1st,
  input  logic [WIDTH-1:0]    rx2nd,
  output logic                posneg,
  output logic [DLYW-1:0]     delay,
  output logic                mux_clr,
  output logic                mux_clock_en,
  output logic [WIDTH-1:0]    tx1st,
  output logic [WIDTH-1:0]    tx2nd,
  output logic                busy,
  output logic                done,
  output logic                nogood,
  output logic [2*NSTEPS-1:0] goodspots,
  output logic [DLYW:0]       best_len
);

  localparam int TW = $clog2(SETTLE + NCHECK + CLR_CYCLES) + 1;

  scan_state_e         state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                p_q, p_d, err_q, err_d;
  logic [DLYW-1:0]     d_q, d_d;
  logic [WIDTH-1:0]    prev_q, cnt_q, cnt_d, tx1st_q, tx1st_d, tx2nd_q, tx2nd_d;
  logic [2*NSTEPS-1:0] gs_q, gs_d;
  logic [DLYW:0]       blen_q, blen_d;
  logic                nogood_q, nogood_d, ran_q, ran_d, aborted_q, aborted_d;
  logic                wf_start, wf_done, wf_posneg, wf_nogood;
  logic [DLYW-1:0]     wf_delay;
  logic [DLYW:0]       wf_len;
  logic                last_setting, abort_take, cyc_ok;

  assign last_setting = p_q && (d_q == DLYW'(NSTEPS - 1));
  assign abort_take   = abort && (state_q != ST_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_take) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = ST_CLR;
        ST_CLR:    if (timer_q == TW'(CLR_CYCLES - 1)) state_d = ST_SETTLE;
        ST_SETTLE: if (timer_q == TW'(SETTLE - 1))     state_d = ST_CHECK;
        ST_CHECK:  if (timer_q == TW'(NCHECK - 1))     state_d = ST_RECORD;
        ST_RECORD: state_d = ST_NEXT;
        ST_NEXT:   state_d = last_setting ? ST_PICK : ST_CLR;
        ST_PICK:   if (wf_done) state_d = ST_DONE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done         = (state_q == ST_DONE);
    // Clear is held until the first scan, and pulsed once after an abort.
    mux_clr      = (state_q == ST_CLR) || ((state_q == ST_IDLE) && (!ran_q || aborted_q));
    mux_clock_en = ran_q;
    wf_start     = (state_q == ST_NEXT) && last_setting && !abort;
  end

  always_comb begin
    timer_d   = (state_d != state_q) ? '0 : timer_q + 1'b1;
    p_d       = p_q;
    d_d       = d_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    tx1st_d   = tx1st_q;
    tx2nd_d   = tx2nd_q;
    gs_d      = gs_q;
    blen_d    = blen_q;
    nogood_d  = nogood_q;
    ran_d     = ran_q;
    aborted_d = 1'b0;
    cyc_ok    = (rx2nd == ~rx1st) && (rx1st == prev_q + 1'b1);
    if (busy) begin
      cnt_d   = cnt_q + 1'b1;
      tx1st_d = cnt_q;
      tx2nd_d = ~cnt_q;
    end
    if (abort_take) begin
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            gs_d     = '0;
            p_d      = 1'b0;
            d_d      = '0;
            blen_d   = '0;
            nogood_d = 1'b0;
            ran_d    = 1'b1;
          end
        end
        ST_SETTLE: err_d = 1'b0;
        ST_CHECK:  if (timer_q != '0 && !cyc_ok) err_d = 1'b1;
        ST_RECORD: gs_d = gs_q | ({{(2*NSTEPS-1){1'b0}}, ~err_q} << gs_idx(32'(p_q), 32'(d_q), NSTEPS));
        ST_NEXT: begin
          if (d_q != DLYW'(NSTEPS - 1)) begin
            d_d = d_q + 1'b1;
          end else if (!p_q) begin
            p_d = 1'b1;
            d_d = '0;
          end
        end
        ST_PICK: begin
          if (wf_done) begin
            p_d      = wf_posneg;
            d_d      = wf_delay;
            blen_d   = wf_len;
            nogood_d = wf_nogood;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      p_q       <= 1'b0;
      d_q       <= '0;
      err_q     <= 1'b0;
      prev_q    <= '0;
      cnt_q     <= '0;
      tx1st_q   <= '0;
      tx2nd_q   <= '0;
      gs_q      <= '0;
      blen_q    <= '0;
      nogood_q  <= 1'b0;
      ran_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      p_q       <= p_d;
      d_q       <= d_d;
      err_q     <= err_d;
      prev_q    <= rx1st;
      cnt_q     <= cnt_d;
      tx1st_q   <= tx1st_d;
      tx2nd_q   <= tx2nd_d;
      gs_q      <= gs_d;
      blen_q    <= blen_d;
      nogood_q  <= nogood_d;
      ran_q     <= ran_d;
      aborted_q <= aborted_d;
    end
  end

  alct_mux_window_find #(
    .NSTEPS(NSTEPS),
    .DLYW  (DLYW)
  ) u_window_find (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (wf_start),
    .goodspots  (gs_q),
    .done       (wf_done),
    .best_posneg(wf_posneg),
    .best_delay (wf_delay),
    .best_len   (wf_len),
    .nogood     (wf_nogood)
  );

  assign posneg    = p_q;
  assign delay     = d_q;
  assign tx1st     = tx1st_q;
  assign tx2nd     = tx2nd_q;
  assign nogood    = nogood_q;
  assign goodspots = gs_q;
  assign best_len  = blen_q;

endmodule

// File: tb/tb_alct_mux_phase_scan.sv
// tb/tb_alct_mux_phase_scan.sv - loopback mux model plus reference window search for alct_mux_phase_scan
module tb_alct_mux_phase_scan;

  localparam int WIDTH  = 8;
  localparam int NSTEPS = 16;
  localparam int DLYW   = 4;
  localparam int SETTLE = 4;
  localparam int NCHECK = 16;
  localparam int LO     = 2 * NSTEPS * (3 + SETTLE + NCHECK);
  localparam int HI     = 2 * NSTEPS * (4 + SETTLE + NCHECK) + 2 * NSTEPS + 2;

  logic                clock = 1'b0;
  logic                reset_n, start, abort;
  logic [WIDTH-1:0]    rx1st, rx2nd;
  logic                posneg, mux_clr, mux_clock_en, busy, done, nogood;
  logic [DLYW-1:0]     delay;
  logic [WIDTH-1:0]    tx1st, tx2nd;
  logic [2*NSTEPS-1:0] goodspots;
  logic [DLYW:0]       best_len;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] gmap  = 32'hFFFF_FFFF;
  bit          inject = 1'b0;
  int          inj_cnt = 0;
  logic [WIDTH-1:0] pa [3] = '{default: '0};
  logic [WIDTH-1:0] pb [3] = '{default: '0};

  alct_mux_phase_scan #(
    .WIDTH(WIDTH), .NSTEPS(NSTEPS), .DLYW(DLYW), .SETTLE(SETTLE), .NCHECK(NCHECK)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .rx1st(rx1st), .rx2nd(rx2nd), .posneg(posneg), .delay(delay),
    .mux_clr(mux_clr), .mux_clock_en(mux_clock_en), .tx1st(tx1st), .tx2nd(tx2nd),
    .busy(busy), .done(done), .nogood(nogood), .goodspots(goodspots), .best_len(best_len)
  );

  always #5 clock = ~clock;

  // Mux + cable: 3-cycle loopback, garbage at settings outside gmap, optional one-shot bit flip.
  always @(negedge clock) begin
    logic good;
    pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = tx1st;
    pb[2] = pb[1]; pb[1] = pb[0]; pb[0] = tx2nd;
    if (inject && busy === 1'b1 && posneg === 1'b0 && delay === 4'd5) inj_cnt++;
    else inj_cnt = 0;
    good = ((gmap >> (32'(posneg) * NSTEPS + 32'(delay))) & 32'd1) != 0;
    if (good === 1'b1) begin
      rx1st = pa[2];
      rx2nd = pb[2];
    end else begin
      rx1st = '0;
      rx2nd = '0;
    end
    if (inj_cnt == 12) rx1st = rx1st ^ 8'h10;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Brute force over every (start,end) window; strict '>' keeps phase 0 and earlier runs on ties.
  task automatic ref_window(input logic [31:0] m, output int bp, output int bd, output int bl);
    bp = 0; bd = 0; bl = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int s = 0; s < NSTEPS; s++)
        for (int e = s; e < NSTEPS; e++) begin
          bit all = 1'b1;
          for (int k = s; k <= e; k++)
            if (((m >> (ph * NSTEPS + k)) & 32'd1) == 0) all = 1'b0;
          if (all && (e - s + 1) > bl) begin
            bl = e - s + 1;
            bp = ph;
            bd = s + (bl - 1) / 2;
          end
        end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_posneg"},  64'(posneg), 64'(0));
    chk({pfx, "_delay"},   64'(delay), 64'(0));
    chk({pfx, "_mux_clr"}, 64'(mux_clr), 64'(1));
    chk({pfx, "_clk_en"},  64'(mux_clock_en), 64'(0));
    chk({pfx, "_tx1st"},   64'(tx1st), 64'(0));
    chk({pfx, "_tx2nd"},   64'(tx2nd), 64'(0));
    chk({pfx, "_busy"},    64'(busy), 64'(0));
    chk({pfx, "_done"},    64'(done), 64'(0));
    chk({pfx, "_nogood"},  64'(nogood), 64'(0));
    chk({pfx, "_gs"},      64'(goodspots), 64'(0));
    chk({pfx, "_bestlen"}, 64'(best_len), 64'(0));
  endtask

  task automatic run_scan(input string tag, input logic [31:0] m, input bit inj, input int mid_start);
    int n = 0;
    bit seen = 1'b0;
    int bp, bd, bl;
    logic [31:0] expgs;
    gmap = m;
    inject = inj;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) n++;
      start = (i == mid_start);
      @(negedge clock);
    end
    start = 1'b0;
    inject = 1'b0;
    expgs = inj ? (m & ~32'h0000_0020) : m;
    ref_window(expgs, bp, bd, bl);
    chk({tag, "_done"},    64'(seen), 64'(1));
    chk({tag, "_len_ok"},  64'(n >= LO && n <= HI), 64'(1));
    chk({tag, "_gs"},      64'(goodspots), 64'(expgs));
    chk({tag, "_posneg"},  64'(posneg), 64'(bp));
    chk({tag, "_delay"},   64'(delay), 64'(bd));
    chk({tag, "_bestlen"}, 64'(best_len), 64'(bl));
    chk({tag, "_nogood"},  64'(nogood), 64'(bl == 0));
    chk({tag, "_busy"},    64'(busy), 64'(0));
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset_vals("idle");

    run_scan("perfect", 32'hFFFF_FFFF, 1'b0, -1);
    run_scan("p1win",   32'h07F0_0000, 1'b0, -1);
    run_scan("tie",     32'h0000_0E07, 1'b0, -1);
    run_scan("inject",  32'hFFFF_FFFF, 1'b1, -1);
    run_scan("allbad",  32'h0000_0000, 1'b0, -1);
    run_scan("rand0",   $urandom() | $urandom(), 1'b0, 100);
    run_scan("rand1",   $urandom() | $urandom(), 1'b0, -1);

    // Abort during SETTLE of p=0, d=3.
    gmap = 32'hFFFF_FFFF;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2000 && cnt < 4; i++) begin
      @(negedge clock);
      if (busy === 1'b1 && posneg === 1'b0 && delay === 4'd3) cnt++;
    end
    chk("abort_reach", 64'(cnt), 64'(4));
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    chk("abort_busy",    64'(busy), 64'(0));
    chk("abort_done",    64'(done), 64'(0));
    chk("abort_clr",     64'(mux_clr), 64'(1));
    chk("abort_clk_en",  64'(mux_clock_en), 64'(1));
    chk("abort_posneg",  64'(posneg), 64'(0));
    chk("abort_delay",   64'(delay), 64'(3));
    @(negedge clock);
    chk("abort_clr_end", 64'(mux_clr), 64'(0));
    chk("abort_idle",    64'(busy), 64'(0));

    // Asynchronous reset in the middle of CHECK at p=0, d=2.
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2000 && cnt < 10; i++) begin
      @(negedge clock);
      if (busy === 1'b1 && posneg === 1'b0 && delay === 4'd2) cnt++;
    end
    chk("midrst_reach", 64'(cnt), 64'(10));
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
